// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, PC step, default reset PC.
// The FAULT state is present only when FETCH_ALIGN_CHECK_EN is defined.
// `WORD is the global machine-word width define.
`ifndef WORD
`define WORD 32
`endif

package cpu_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
`ifdef FETCH_ALIGN_CHECK_EN
      ,ST_FAULT = 2'd3
`endif
   } fetch_state_e;

   localparam int unsigned        PC_STEP          = 4;
   localparam logic [`WORD-1:0]   DEFAULT_RESET_PC = '0;

   // Clear the two byte-offset bits of an address.
   function automatic logic [`WORD-1:0] align_word(input logic [`WORD-1:0] a);
      return a & ~(`WORD'(3));
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer for the fetch unit: DEPTH entries of {pc, instr},
// occupancy count output and a synchronous flush that overrides push/pop.
// DEPTH must be a power of two (2, 4 or 8) so the pointers wrap naturally.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter  int unsigned DEPTH   = 2,
   parameter  int unsigned ENTRY_W = 2 * `WORD,
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W   = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               push,
   input  logic [ENTRY_W-1:0] push_data,
   input  logic               pop,
   output logic [ENTRY_W-1:0] head_data,
   output logic [CNT_W-1:0]   count
);

   localparam logic [PTR_W-1:0] PTR_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   // Pointer and occupancy update; flush empties the buffer regardless of push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are only meaningful while counted, so no reset.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, buffers in-order
// responses with their PC, and handles redirects by flushing the buffer and
// dropping responses still in flight (DRAIN).
// Optional: FETCH_ALIGN_CHECK_EN adds fetch_fault and a FAULT state entered on
// misaligned redirects; without it redirect targets are silently word-aligned.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [`WORD-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned      FIFO_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [`WORD-1:0] imem_req_addr,
   input  logic             imem_rsp_valid,
   input  logic [`WORD-1:0] imem_rsp_data,
   output logic             instr_valid,
   input  logic             instr_ready,
   output logic [`WORD-1:0] instr,
   output logic [`WORD-1:0] instr_pc,
   input  logic             redirect_valid,
   input  logic [`WORD-1:0] redirect_pc
`ifdef FETCH_ALIGN_CHECK_EN
   ,output logic            fetch_fault
`endif
);

   localparam int unsigned      CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [`WORD-1:0] STEP    = `WORD'(PC_STEP);

   fetch_state_e       state_q, state_d;
   logic [`WORD-1:0]   fetch_pc_q, fetch_pc_d;
   logic [`WORD-1:0]   rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0]   outstanding_q, outstanding_d;
   logic [CNT_W-1:0]   discard_q, discard_d;

   logic [CNT_W-1:0]   fifo_count;
   logic [2*`WORD-1:0] fifo_head;
   logic [CNT_W:0]     occupancy;
   logic               req_valid;
   logic               accept;
   logic               push;
   logic               pop;
   logic               flush;
   logic               buf_valid;

   assign buf_valid = (fifo_count != '0);
   assign occupancy = {1'b0, outstanding_q} + {1'b0, fifo_count};

   // Next-state, request issue, buffer control and redirect handling.
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      req_valid     = 1'b0;
      push          = 1'b0;
      pop           = 1'b0;
      flush         = 1'b0;

      // Only request while every in-flight response is guaranteed a buffer slot.
      if ((state_q == ST_RUN) && (occupancy < DEPTH_C)) req_valid = 1'b1;
      accept = req_valid && imem_req_ready;
      pop    = buf_valid && instr_ready;

      case ({accept, imem_rsp_valid})
         2'b10:   outstanding_d = outstanding_q + CNT_ONE;
         2'b01:   outstanding_d = outstanding_q - CNT_ONE;
         default: outstanding_d = outstanding_q;
      endcase

      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (accept) fetch_pc_d = fetch_pc_q + STEP;
            if (imem_rsp_valid) begin
               push     = 1'b1;
               rsp_pc_d = rsp_pc_q + STEP;
            end
         end
         ST_DRAIN: begin
            if (imem_rsp_valid) begin
               discard_d = discard_q - CNT_ONE;
               if (discard_d == '0) state_d = ST_RUN;
            end
         end
`ifdef FETCH_ALIGN_CHECK_EN
         ST_FAULT: begin
            if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CNT_ONE;
         end
`endif
         default: state_d = ST_BOOT;
      endcase

      // Redirect wins over push/pop; anything accepted this cycle is stale too.
      // A redirect during the single BOOT cycle is ignored.
      if (redirect_valid && (state_q != ST_BOOT)) begin
         flush      = 1'b1;
         push       = 1'b0;
         pop        = 1'b0;
         discard_d  = outstanding_d;
         state_d    = (outstanding_d != '0) ? ST_DRAIN : ST_RUN;
         fetch_pc_d = align_word(redirect_pc);
         rsp_pc_d   = align_word(redirect_pc);
`ifdef FETCH_ALIGN_CHECK_EN
         if (redirect_pc[1:0] != 2'b00) begin
            state_d    = ST_FAULT;
            fetch_pc_d = fetch_pc_q;
            rsp_pc_d   = rsp_pc_q;
         end
`endif
      end
   end

   // FSM and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_BOOT;
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .ENTRY_W (2 * `WORD)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push),
      .push_data ({rsp_pc_q, imem_rsp_data}),
      .pop       (pop),
      .head_data (fifo_head),
      .count     (fifo_count)
   );

   assign imem_req_valid = req_valid;
   assign imem_req_addr  = fetch_pc_q;
   assign instr_valid    = buf_valid;
   // Gate the head entry so stale storage never shows on the core interface.
   assign instr          = buf_valid ? fifo_head[`WORD-1:0]         : '0;
   assign instr_pc       = buf_valid ? fifo_head[2*`WORD-1:`WORD]   : '0;
`ifdef FETCH_ALIGN_CHECK_EN
   assign fetch_fault    = (state_q == ST_FAULT);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: randomized memory/core/redirect stimulus, an
// epoch-tagged reference model of the fetch stream and a scoreboard monitor.
// Build with FETCH_ALIGN_CHECK_EN to also exercise the misaligned-redirect fault.
module tb_fetch_unit;

   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        fetch_fault;
`endif

   fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
`ifdef FETCH_ALIGN_CHECK_EN
      ,.fetch_fault   (fetch_fault)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] pc;
      int unsigned tag;
      int          cyc;
   } pend_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   pend_t       pending[$];    // memory: accepted requests awaiting response
   exp_t        sbq[$];        // instructions the core should see, in order
   logic [31:0] popped[$];     // pcs the core actually consumed

   int          n_checks = 0;
   int          n_err    = 0;
   int          cyc      = 0;
   int          n_acc    = 0;
   int unsigned epoch    = 0;
   bit          fault    = 1'b0;
   bit          in_boot  = 1'b0;
   bit          redir_prev = 1'b0;
   logic [31:0] model_pc = RESET_PC;
   bit          wrap_seen = 1'b0;
   bit          last_acc_valid = 1'b0;
   logic [31:0] last_acc_addr = '0;

   int unsigned p_ready = 100, p_rsp = 100, p_iready = 100, p_redir = 0;
   bit          force_redir = 1'b0;
   bit          force_busy  = 1'b0;
   logic [31:0] force_pc    = '0;
   bit          rsp_now     = 1'b0;
   bit          redir       = 1'b0;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1357};
   endfunction

   function automatic logic [31:0] rand_target();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(3))
         0:       return r;
         1:       return r & 32'h0000_0FFC;
         2:       return 32'hFFFF_FFF0 + 32'($urandom_range(3) * 4);
         default: return r & 32'hFFFF_FFFC;
      endcase
   endfunction

   function automatic bit any_stale();
      foreach (pending[i]) if (pending[i].tag != epoch) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_pop(input string name, input int idx, input logic [31:0] exp);
      if (popped.size() > idx) chk(name, popped[idx], exp);
      else begin
         n_checks++;
         n_err++;
         $display("FAIL %s: no instruction consumed, expected pc %h", name, exp);
      end
   endtask

   // One clock cycle of stimulus, entered at a falling edge.
   task automatic cycle_body();
      logic [31:0] tgt;
      pend_t       pe;
      exp_t        ex;
      bit          exp_req;
      cyc++;
      imem_req_ready = ($urandom_range(99) < p_ready);
      instr_ready    = ($urandom_range(99) < p_iready);
      rsp_now        = (pending.size() > 0) && (pending[0].cyc < cyc) && ($urandom_range(99) < p_rsp);
      imem_rsp_valid = rsp_now;
      imem_rsp_data  = rsp_now ? memfn(pending[0].addr) : $urandom;
      redir = 1'b0;
      tgt   = $urandom;
      if (force_redir) begin
         if (!force_busy || (imem_req_valid && instr_valid)) begin
            redir       = 1'b1;
            tgt         = force_pc;
            force_redir = 1'b0;
         end
      end else if ($urandom_range(999) < p_redir) begin
         redir = 1'b1;
         tgt   = rand_target();
      end
      redirect_valid = redir;
      redirect_pc    = tgt;
      #1;
      exp_req = !in_boot && !fault && !any_stale() && ((pending.size() + sbq.size()) < DEPTH);
      if (redir_prev) chk("flush_instr_valid", 32'(instr_valid), 32'(0));
      chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
`ifdef FETCH_ALIGN_CHECK_EN
      chk("fetch_fault", 32'(fetch_fault), 32'(fault));
`endif
      if (imem_req_valid && imem_req_ready) begin
         chk("req_addr", imem_req_addr, model_pc);
         if (last_acc_valid && last_acc_addr == 32'hFFFF_FFFC && imem_req_addr == 32'h0) wrap_seen = 1'b1;
         last_acc_valid = 1'b1;
         last_acc_addr  = imem_req_addr;
         pe.addr = imem_req_addr;
         pe.pc   = model_pc;
         pe.tag  = epoch;
         pe.cyc  = cyc;
         pending.push_back(pe);
         model_pc += 32'd4;
         n_acc++;
      end
      if (rsp_now) begin
         pe = pending.pop_front();
         if (pe.tag == epoch && !redir && !fault) begin
            ex.pc   = pe.pc;
            ex.data = memfn(pe.pc);
            sbq.push_back(ex);
         end
      end
      if (redir) begin
         sbq.delete();
         epoch++;
         if (ALIGN_CHK && tgt[1:0] != 2'b00) fault = 1'b1;
         else begin
            fault    = 1'b0;
            model_pc = tgt & 32'hFFFF_FFFC;
         end
      end
      redir_prev = redir;
      in_boot    = 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
      cycle_body();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst_n          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      pending.delete();
      sbq.delete();
      epoch++;
      fault      = 1'b0;
      model_pc   = RESET_PC;
      redir_prev = 1'b0;
      n_acc      = 0;
      repeat (n) begin
         #1;
         chk("rst_req_valid", 32'(imem_req_valid), 32'(0));
         chk("rst_instr_valid", 32'(instr_valid), 32'(0));
         chk("rst_instr", instr, 32'h0);
         chk("rst_instr_pc", instr_pc, 32'h0);
         chk("rst_fetch_pc", imem_req_addr, RESET_PC);
`ifdef FETCH_ALIGN_CHECK_EN
         chk("rst_fetch_fault", 32'(fetch_fault), 32'(0));
`endif
         @(negedge clk);
      end
      rst_n   = 1'b1;
      in_boot = 1'b1;
      cycle_body();
   endtask

   task automatic fire_redirect(input logic [31:0] pc, input bit busy);
      force_pc    = pc;
      force_busy  = busy;
      force_redir = 1'b1;
      for (int i = 0; i < 50 && force_redir; i++) step();
      if (force_redir) begin
         n_checks++;
         n_err++;
         $display("FAIL redirect_timeout: trigger condition not met within 50 cycles");
         force_redir = 1'b0;
      end
   endtask

   task automatic knobs(input int unsigned r, input int unsigned s, input int unsigned i, input int unsigned d);
      p_ready  = r;
      p_rsp    = s;
      p_iready = i;
      p_redir  = d;
   endtask

   // Scoreboard monitor: compare every instruction the core consumes.
   exp_t mon_e;
   always @(negedge clk) begin
      #2;
      if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
         if (sbq.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL instr_unexpected: got pc %h data %h, nothing expected", instr_pc, instr);
         end else begin
            mon_e = sbq.pop_front();
            chk("instr_pc", instr_pc, mon_e.pc);
            chk("instr_data", instr, mon_e.data);
         end
         popped.push_back(instr_pc);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      // Basic streaming from reset, always-ready memory and core.
      knobs(100, 100, 100, 0);
      do_reset(3);
      base = popped.size();
      run(30);
      chk_pop("first_pc", base, 32'h0);
      chk_pop("second_pc", base + 1, 32'h4);
      chk_pop("third_pc", base + 2, 32'h8);

      // Core stalls: buffer fills, requests stop at DEPTH, nothing lost.
      knobs(100, 100, 0, 0);
      do_reset(2);
      run(11);
      chk("stall_req_count", 32'(n_acc), 32'(DEPTH));
      chk("stall_req_valid", 32'(imem_req_valid), 32'(0));
      base = popped.size();
      knobs(100, 100, 100, 0);
      run(10);
      chk_pop("resume_pc0", base, 32'h0);
      chk_pop("resume_pc1", base + 1, 32'h4);

      // Redirect with two requests outstanding: drain, then restart at 0x100.
      knobs(100, 0, 100, 0);
      do_reset(2);
      run(3);
      chk("pre_redir_acc", 32'(n_acc), 32'd2);
      fire_redirect(32'h0000_0100, 1'b0);
      step();
      chk("drain_no_req", 32'(imem_req_valid), 32'(0));
      base = popped.size();
      knobs(100, 100, 100, 0);
      run(12);
      chk_pop("after_drain_pc", base, 32'h0000_0100);

      // Redirect coinciding with a request accept and a core pop.
      run(10);
      fire_redirect(32'h0000_0040, 1'b1);
      step();
      chk("busy_redir_drain", 32'(imem_req_valid), 32'(0));
      base = popped.size();
      run(12);
      chk_pop("busy_redir_pc", base, 32'h0000_0040);

      // Fetch PC wraps around the top of the address space.
      wrap_seen = 1'b0;
      fire_redirect(32'hFFFF_FFF8, 1'b0);
      run(12);
      chk("pc_wrap", 32'(wrap_seen), 32'd1);

      // Randomized traffic with back-pressure, latency and redirects.
      knobs(70, 60, 70, 30);
      run(3000);

`ifdef FETCH_ALIGN_CHECK_EN
      // Misaligned redirect faults; an aligned one recovers.
      knobs(100, 100, 100, 0);
      run(5);
      fire_redirect(32'h0000_0102, 1'b0);
      base = n_acc;
      run(5);
      chk("fault_flag", 32'(fetch_fault), 32'd1);
      chk("fault_no_req", 32'(n_acc), 32'(base));
      base = popped.size();
      fire_redirect(32'h0000_0200, 1'b0);
      run(12);
      chk("fault_cleared", 32'(fetch_fault), 32'd0);
      chk_pop("fault_resume_pc", base, 32'h0000_0200);
`endif

      // Reset in the middle of random traffic abandons everything in flight.
      knobs(70, 60, 70, 30);
      run(40);
      knobs(100, 100, 100, 0);
      do_reset(3);
      base = popped.size();
      run(20);
      chk_pop("post_reset_pc", base, RESET_PC);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, sets the instruction buffer entry count; legal values are 2, 4 and 8.
REQ-003 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  `WORD  fetch address.
- imem_rsp_valid  in  1  in-order read data valid; never back-pressured.
- imem_rsp_data  in  `WORD  read data.
- instr_valid  out  1  instr is valid for the core.
- instr_ready  in  1  core consumes instr.
- instr  out  `WORD  instruction word.
- instr_pc  out  `WORD  address of instr.
- redirect_valid  in  1  taken branch or jump.
- redirect_pc  in  `WORD  new fetch address.
- fetch_fault  out  1  misaligned redirect flag; exists only with FETCH_ALIGN_CHECK_EN.

Function
REQ-004 The FSM SHALL have states BOOT, RUN, DRAIN and FAULT; FAULT exists only with the macro.
REQ-005 BOOT SHALL last exactly one cycle after rst_n deasserts, issue no request, then go to RUN.
REQ-006 In RUN, imem_req_valid SHALL be 1 iff outstanding + fifo_count < FIFO_DEPTH.
REQ-007 A request is accepted on imem_req_valid && imem_req_ready; fetch_pc then advances by 4 and wraps modulo 2^`WORD.
REQ-008 imem_req_addr SHALL hold fetch_pc and remain stable while imem_req_valid=1 and imem_req_ready=0.
REQ-009 The outstanding counter SHALL increment on accept, decrement on imem_rsp_valid, and stay unchanged when both happen in the same cycle.
REQ-010 A non-discarded response SHALL be written to the FIFO with its PC; instr_valid rises no earlier than the cycle after imem_rsp_valid.
REQ-011 The FIFO SHALL pop on instr_valid && instr_ready; a push and a pop in the same cycle leave fifo_count unchanged.
REQ-012 A response SHALL never be dropped for lack of space; REQ-006 guarantees a free slot.
REQ-013 On redirect_valid the block SHALL, in that cycle:
- flush the FIFO, so instr_valid=0 the next cycle;
- set fetch_pc=redirect_pc;
- set discard_cnt = outstanding after this cycle's accept and response;
- go to DRAIN if discard_cnt>0, else RUN.
REQ-014 In DRAIN, imem_req_valid=0; each response decrements discard_cnt and is not written; at 0 the FSM enters RUN.
REQ-015 Any redirect_valid (RUN or DRAIN) overrides a simultaneous pop or push and restarts REQ-013.
REQ-016 A request already presented and accepted in the redirect cycle SHALL be counted as discarded.

Reset
REQ-017 While rst_n=0, state SHALL be BOOT and fetch_pc=RESET_PC.
REQ-018 While rst_n=0, outstanding, discard_cnt and fifo_count SHALL be 0.
REQ-019 While rst_n=0, the outputs imem_req_valid, instr_valid and fetch_fault SHALL be 0, and instr and instr_pc SHALL be 0.
REQ-020 Reset asserted mid-operation SHALL abandon all in-flight requests; the memory is reset together with this block.

Configuration
REQ-021 With FETCH_ALIGN_CHECK_EN defined, a redirect with redirect_pc[1:0]!=0 SHALL:
- enter FAULT, issue no requests and set fetch_fault=1;
- still discard pending responses;
- stay in FAULT until an aligned redirect, which clears fetch_fault and applies REQ-013.
REQ-022 Without FETCH_ALIGN_CHECK_EN, redirect_pc[1:0] SHALL be forced to 0, and the fetch_fault port and FAULT state SHALL be absent.

Structure
REQ-023 The shared package cpu_pkg SHALL hold the fetch state enum, PC_STEP=4 and the default RESET_PC; `WORD remains the global define.
REQ-024 The FIFO SHALL be the sub-module fetch_fifo, parameterised by depth, with {pc,instr} entries, a count output and a synchronous flush.

Verification
REQ-025 Reset, always-ready memory with 1-cycle latency, instr_ready=1 -> first request addr 0x0 on the cycle after BOOT; instr_pc sequence 0x0,0x4,0x8,... with data matching memory.
REQ-026 instr_ready=0 for 10 cycles, FIFO_DEPTH=2 -> exactly 2 requests issued, imem_req_valid=0 afterwards, no response lost; resume -> in-order 0x0,0x4.
REQ-027 Redirect to 0x100 with 2 requests outstanding -> DRAIN, 2 responses dropped, next instr_pc=0x100.
REQ-028 Redirect in the same cycle as a request accept and a pop -> the accepted request's response is discarded and instr_valid=0 the next cycle.
REQ-029 With the macro, redirect_pc=0x102 -> fetch_fault=1 and no requests; a later redirect to 0x200 -> fetch_fault=0 and fetch resumes at 0x200.
REQ-030 fetch_pc=0xFFFF_FFFC -> the next request address is 0x0000_0000.
